eth_fcs_insert: RTL and testbench
=================================

Name: eth_fcs_insert

Overview:
- TX-path controller that sequences the combinational crc32 datapath over each outgoing Ethernet frame and appends the 4-byte FCS.
- Accepts a byte-wide AXI-Stream frame (preamble/SFD excluded), passes it through one register stage, then emits the FCS bytes.
- Owns the CRC state register that crc32 needs externally. Sits between the TX frame source and the MAC TX/GMII serializer.

Parameters:
- DATA_WIDTH, 8, stream byte width; fixed at 8, since the crc32 LUT is byte-indexed.
- MIN_FRAME_BYTES, 60, minimum payload+header byte count before FCS; used only with the pad option.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  synchronous active-low reset
- s_axis_tdata  in  8  input frame byte
- s_axis_tvalid  in  1  input byte valid
- s_axis_tlast  in  1  last byte of frame
- s_axis_tready  out  1  block accepts input byte
- m_axis_tdata  out  8  output byte (frame, then FCS)
- m_axis_tvalid  out  1  output byte valid
- m_axis_tlast  out  1  last FCS byte
- m_axis_tready  in  1  downstream accepts output byte
- o_busy  out  1  frame in progress (state != IDLE or output register occupied)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset_n is synchronous and active-low.
- Reset: state=IDLE, crc_state=32'hFFFF_FFFF, byte count=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 during reset, o_busy=0.
  - Reset mid-frame aborts the frame immediately; no partial FCS is emitted.
- Output stage: a single register.
  - out_free = !m_axis_tvalid || m_axis_tready.
  - Output data/valid/last hold stable while m_axis_tvalid && !m_axis_tready.
- Internal crc32 instance: i_byte = the accepted data byte, i_crc_state = crc_state. On every accepted data/pad byte, crc_state <= o_crc_state.
- IDLE and DATA states:
  - s_axis_tready = out_free.
  - An accepted byte is registered to the output 1 cycle later (latency 1), with m_axis_tlast=0.
  - The byte counter increments and saturates at MIN_FRAME_BYTES.
- Accepted byte with s_axis_tlast=1:
  - fcs_reg <= crc_out of that byte.
  - crc_state <= 32'hFFFF_FFFF.
  - Transition to FCS, or to PAD when the pad option applies.
- IDLE->DATA on the first accepted byte. A one-byte frame goes IDLE->FCS directly.
- FCS state:
  - s_axis_tready=0.
  - Emits fcs_reg[7:0], [15:8], [23:16], [31:24] on successive out_free cycles, tracked by a 2-bit index.
  - m_axis_tlast=1 on byte index 3.
  - After that byte is loaded, go to IDLE and clear the byte counter.
- Back-to-back frames: the first byte of the next frame can be accepted the cycle after the last FCS byte is loaded into the output register. There are no idle gaps and no bubbles at steady state with m_axis_tready=1.
- Throughput: 1 byte/cycle with tready held high. A frame of N bytes occupies N+4 output beats.
- Input tvalid low mid-frame: stall, no state change. tlast is only sampled on accepted beats.

Optional Feature:
- Macro: ETH_FCS_PAD_EN.
- Defined:
  - If byte count < MIN_FRAME_BYTES at the tlast beat, enter PAD.
  - PAD: s_axis_tready=0. Emit 8'h00 bytes, each fed through crc32 and counted, until count == MIN_FRAME_BYTES. Then latch fcs_reg from the final pad byte's crc_out and go to FCS.
  - tlast on input when count ≥ MIN_FRAME_BYTES skips PAD.
- Undefined:
  - The PAD state and comparator are not built. Frames of any length go straight to FCS.

Test Plan:
- Bytes "123456789" (31..39 hex), tlast on 0x39, tready=1 -> output 31..39 then 26 39 F4 CB, tlast on CB. 13 beats, 1-cycle latency.
- Two 64-byte frames back-to-back, random payload, tready=1 -> FCS of each matches the software CRC32 model. No bubble between frame 1's last FCS beat and frame 2's first byte. crc_state re-initialized.
- Random m_axis_tready (50%) and s_axis_tvalid (50%) on a 100-byte frame -> output byte stream identical to the tready=1 case; tdata stable while tvalid && !tready.
- ETH_FCS_PAD_EN defined, 14-byte frame -> 14 bytes + 46 x 00 + 4 FCS bytes equal to the CRC of the 60-byte padded frame. Undefined: 14 + 4 beats.
- i_reset_n=0 for 1 cycle during FCS byte 2 -> m_axis_tvalid=0 next cycle, state IDLE. A following "123456789" frame yields FCS 26 39 F4 CB.
- One-byte frame 0x00 with tlast -> output 00 then 8D EF 02 D2, tlast on D2.

Source files
------------

// File: rtl/eth_fcs_insert.sv
// Byte-wide Ethernet TX FCS inserter: forwards the frame, then appends the CRC-32 FCS LSB-first.
// Optional zero padding to MIN_FRAME_BYTES is built only when ETH_FCS_PAD_EN is defined.

module crc32 (
  input  logic [7:0]  i_byte,
  input  logic [31:0] i_crc_state,
  output logic [31:0] o_crc_state,
  output logic [31:0] o_crc_out
);

  // One LUT entry for the reflected polynomial 0xEDB88320, generated by shifting the index 8 times.
  function automatic logic [31:0] lut_entry(input logic [7:0] idx);
    logic [31:0] c;
    c = {24'd0, idx};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign o_crc_state = (i_crc_state >> 8) ^ lut_entry(i_crc_state[7:0] ^ i_byte);
  assign o_crc_out   = ~o_crc_state;

endmodule

module eth_fcs_insert #(
  parameter int DATA_WIDTH      = 8,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(MIN_FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    FCS  = 2'd3
  } state_t;

  state_t           state;
  logic [31:0]      crc_state;
  logic [31:0]      fcs_reg;
  logic [1:0]       fcs_idx;
  logic [CNT_W-1:0] byte_cnt;

  logic             out_free;
  logic             accept;
  logic [7:0]       crc_byte;
  logic [31:0]      crc_next;
  logic [31:0]      crc_out;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       fcs_byte;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = i_reset_n && ((state == IDLE) || (state == DATA)) && out_free;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign o_busy        = (state != IDLE) || m_axis_tvalid;

  // Counter saturates so that long frames never wrap back under the minimum.
  assign cnt_inc  = (byte_cnt == MIN_CNT) ? byte_cnt : byte_cnt + 1'b1;
  assign fcs_byte = fcs_reg[{fcs_idx, 3'b000} +: 8];

`ifdef ETH_FCS_PAD_EN
  assign crc_byte = (state == PAD) ? 8'h00 : s_axis_tdata;
`else
  assign crc_byte = s_axis_tdata;
`endif

  crc32 u_crc32 (
    .i_byte      (crc_byte),
    .i_crc_state (crc_state),
    .o_crc_state (crc_next),
    .o_crc_out   (crc_out)
  );

  // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      crc_state     <= 32'hFFFF_FFFF;
      fcs_reg       <= '0;
      fcs_idx       <= '0;
      byte_cnt      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      // A consumed beat empties the output register unless a new one is loaded below.
      if (out_free) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      case (state)
        IDLE, DATA: begin
          if (accept) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            crc_state     <= crc_next;
            byte_cnt      <= cnt_inc;
            if (s_axis_tlast) begin
`ifdef ETH_FCS_PAD_EN
              if (cnt_inc < MIN_CNT) begin
                state <= PAD;
              end else begin
                fcs_reg   <= crc_out;
                crc_state <= 32'hFFFF_FFFF;
                state     <= FCS;
              end
`else
              fcs_reg   <= crc_out;
              crc_state <= 32'hFFFF_FFFF;
              state     <= FCS;
`endif
            end else begin
              state <= DATA;
            end
          end
        end

`ifdef ETH_FCS_PAD_EN
        PAD: begin
          if (out_free) begin
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            crc_state     <= crc_next;
            byte_cnt      <= cnt_inc;
            if (cnt_inc == MIN_CNT) begin
              fcs_reg   <= crc_out;
              crc_state <= 32'hFFFF_FFFF;
              state     <= FCS;
            end
          end
        end
`endif

        FCS: begin
          if (out_free) begin
            m_axis_tdata  <= fcs_byte;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (fcs_idx == 2'd3);
            fcs_idx       <= fcs_idx + 2'd1;
            if (fcs_idx == 2'd3) begin
              state    <= IDLE;
              byte_cnt <= '0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_fcs_insert.sv
// Self-checking bench for eth_fcs_insert: table vectors, random frames against a bitwise CRC-32 model,
// back-to-back, backpressure, padding (when ETH_FCS_PAD_EN is defined) and mid-FCS reset.

module tb_eth_fcs_insert;

  localparam int MIN_BYTES = 60;

  logic       clk;
  logic       i_reset_n;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tlast;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tready;
  logic       o_busy;

  eth_fcs_insert #(.DATA_WIDTH(8), .MIN_FRAME_BYTES(MIN_BYTES)) dut (
    .i_clk         (clk),
    .i_reset_n     (i_reset_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Observed output beats and expected stream.
  logic [7:0] out_d[$];
  logic       out_l[$];
  int         out_c[$];
  logic [7:0] exp_q[$];
  int         first_in_cyc;
  bit         rand_ready = 1'b0;
  bit         hold_pending = 1'b0;
  logic [7:0] hold_data;

  always @(negedge clk) begin
    if (hold_pending) begin
      check("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
      check("hold_data", {24'd0, m_axis_tdata}, {24'd0, hold_data});
    end
    if (i_reset_n && m_axis_tvalid && m_axis_tready) begin
      out_d.push_back(m_axis_tdata);
      out_l.push_back(m_axis_tlast);
      out_c.push_back(cyc);
    end
    hold_pending = i_reset_n && m_axis_tvalid && !m_axis_tready;
    hold_data    = m_axis_tdata;
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference CRC-32: bit-serial over the reflected polynomial, final inversion.
  function automatic logic [31:0] ref_crc(input logic [7:0] f[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (f[i]) begin
      for (int b = 0; b < 8; b++) begin
        if ((c[0] ^ f[i][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic add_expected(input logic [7:0] f[$]);
    logic [7:0]  p[$];
    logic [31:0] fcs;
    p = f;
`ifdef ETH_FCS_PAD_EN
    while (p.size() < MIN_BYTES) p.push_back(8'h00);
`endif
    fcs = ref_crc(p);
    foreach (p[i]) exp_q.push_back(p[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
  endtask

  task automatic start_test();
    out_d.delete();
    out_l.delete();
    out_c.delete();
    exp_q.delete();
    first_in_cyc = -1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the tlast beat is accepted.
  task automatic send_frame(input logic [7:0] f[$], input bit rand_valid);
    int t;
    foreach (f[i]) begin
      if (rand_valid) begin
        while ($urandom_range(0, 1) == 0) begin
          s_axis_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = f[i];
      s_axis_tlast  = (i == f.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        t++;
        if (t > 2000) begin
          check("accept_timeout", 32'd0, 32'd1);
          s_axis_tvalid = 1'b0;
          return;
        end
      end
      if (first_in_cyc < 0) first_in_cyc = cyc;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic compare_stream(input string name, input int nframes);
    int t = 0;
    int bad = -1;
    int nl = 0;
    int lastpos = -1;
    while (out_d.size() < exp_q.size() && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
    check({name, "_beats"}, out_d.size(), exp_q.size());
    for (int i = 0; i < out_d.size() && i < exp_q.size(); i++) begin
      if (out_d[i] !== exp_q[i] && bad < 0) bad = i;
    end
    check({name, "_first_bad_byte_idx"}, bad, -1);
    foreach (out_l[i]) begin
      if (out_l[i]) begin
        nl++;
        lastpos = i;
      end
    end
    check({name, "_tlast_count"}, nl, nframes);
    check({name, "_tlast_pos"}, lastpos, exp_q.size() - 1);
  endtask

  typedef struct {
    int          len;
    logic [7:0]  d[9];
    logic [31:0] fcs;
  } vec_t;

  vec_t       tbl[4];
  logic [7:0] f[$];
  logic [7:0] g[$];
  logic [7:0] digits[$];
  logic [31:0] got_fcs;
  int         n;
  int         t;

  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;
    i_reset_n     = 1'b0;

    tbl[0].len = 9; tbl[0].fcs = 32'hCBF4_3926;
    for (int i = 0; i < 9; i++) tbl[0].d[i] = 8'h31 + 8'(i);
    tbl[1].len = 1; tbl[1].fcs = 32'hD202_EF8D; tbl[1].d[0] = 8'h00;
    tbl[2].len = 1; tbl[2].fcs = 32'hE8B7_BE43; tbl[2].d[0] = 8'h61;
    tbl[3].len = 3; tbl[3].fcs = 32'h3524_41C2;
    tbl[3].d[0] = 8'h61; tbl[3].d[1] = 8'h62; tbl[3].d[2] = 8'h63;
    for (int i = 0; i < 9; i++) digits.push_back(8'h31 + 8'(i));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_s_tready", {31'd0, s_axis_tready}, 32'd1);

    // Table vectors with known FCS values
    foreach (tbl[v]) begin
      start_test();
      f.delete();
      for (int i = 0; i < tbl[v].len; i++) f.push_back(tbl[v].d[i]);
      add_expected(f);
      send_frame(f, 1'b0);
      compare_stream($sformatf("tbl%0d", v), 1);
      n = out_d.size();
      if (n >= 4) begin
        got_fcs = {out_d[n-1], out_d[n-2], out_d[n-3], out_d[n-4]};
`ifdef ETH_FCS_PAD_EN
        check($sformatf("tbl%0d_beats_padded", v), n, MIN_BYTES + 4);
`else
        check($sformatf("tbl%0d_fcs", v), got_fcs, tbl[v].fcs);
`endif
      end
      if (n > 0) check($sformatf("tbl%0d_latency", v), out_c[0] - first_in_cyc, 1);
      if (n > 0) check($sformatf("tbl%0d_no_bubble", v), out_c[n-1] - out_c[0], n - 1);
    end

    // Two 64-byte frames back to back
    start_test();
    f.delete();
    g.delete();
    for (int i = 0; i < 64; i++) f.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 64; i++) g.push_back(8'($urandom_range(0, 255)));
    add_expected(f);
    add_expected(g);
    send_frame(f, 1'b0);
    send_frame(g, 1'b0);
    compare_stream("b2b", 2);
    if (out_d.size() == 136) begin
      check("b2b_gap", out_c[68] - out_c[67], 1);
      check("b2b_span", out_c[135] - out_c[0], 135);
    end

    // 100-byte frame under random input and output handshakes
    start_test();
    f.delete();
    for (int i = 0; i < 100; i++) f.push_back(8'($urandom_range(0, 255)));
    add_expected(f);
    rand_ready = 1'b1;
    send_frame(f, 1'b1);
    compare_stream("rand", 1);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // 14-byte frame: padded to the minimum only when the pad option is built
    start_test();
    f.delete();
    for (int i = 0; i < 14; i++) f.push_back(8'($urandom_range(0, 255)));
    add_expected(f);
    send_frame(f, 1'b0);
    compare_stream("short14", 1);
`ifdef ETH_FCS_PAD_EN
    check("short14_total", out_d.size(), 64);
`else
    check("short14_total", out_d.size(), 18);
`endif

    // Reset while FCS byte 2 sits in the output register
    start_test();
    add_expected(digits);
    n = exp_q.size();
    send_frame(digits, 1'b0);
    t = 0;
    while (out_d.size() != n - 2 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("rst_mid_fcs_reached", {31'd0, (t < 500)}, 32'd1);
    check("rst_mid_pre_data", {24'd0, m_axis_tdata}, {24'd0, exp_q[n-2]});
    i_reset_n = 1'b0;
    #1;
    check("rst_mid_s_tready", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    check("rst_mid_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_mid_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    #1;
    check("rst_mid_idle_ready", {31'd0, s_axis_tready}, 32'd1);
    @(posedge clk);
    #1;
    start_test();
    add_expected(digits);
    send_frame(digits, 1'b0);
    compare_stream("after_rst", 1);
    n = out_d.size();
`ifndef ETH_FCS_PAD_EN
    if (n >= 4) check("after_rst_fcs", {out_d[n-1], out_d[n-2], out_d[n-3], out_d[n-4]}, 32'hCBF4_3926);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
